// File: rtl/booth_muldiv_seq.sv
// booth_muldiv_seq: sequential signed/unsigned multiplier-divider.
//   Multiply: radix-2 Booth, WIDTH+1 steps. Divide: restoring, WIDTH steps
//   plus a sign-fix cycle. Both take WIDTH+2 cycles from accept to valid.
//   Divide by zero finishes in one cycle.
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   start              request, sampled only while idle
//   muordi             0 = multiply, 1 = divide
//   signed_op          1 = two's-complement operands
//   opera1, opera2     multiplicand/dividend, multiplier/divisor
//   result             product, or {remainder, quotient}
//   valid              one-cycle pulse when result is updated
//   busy               operation in flight, start ignored
//   div_by_zero        flagged with valid when the divisor was zero
module booth_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 muordi,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     opera1,
  input  logic [WIDTH-1:0]     opera2,
  output logic [2*WIDTH-1:0]   result,
  output logic                 valid,
  output logic                 busy,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, dbz_pend;

  // Booth registers. A carries two guard bits: with (WIDTH+1)-bit operands,
  // A +/- M can reach 2^(WIDTH+1) in magnitude before the shift.
  logic [WIDTH+1:0] a_reg, m_reg;
  logic [WIDTH:0]   q_reg;
  logic             q_1;

  // Restoring divider: dq shifts the dividend out and the quotient in.
  logic [WIDTH-1:0] dq, dr, dd;

  // Combinational next-step values
  logic [WIDTH+1:0] booth_a, sh_a;
  logic [WIDTH:0]   sh_q;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] trial;
  logic             ext1, ext2, neg1, neg2;

  assign ext1 = signed_op & opera1[WIDTH-1];
  assign ext2 = signed_op & opera2[WIDTH-1];
  assign neg1 = ext1;
  assign neg2 = ext2;

  always_comb begin
    booth_a = a_reg;
    case ({q_reg[0], q_1})
      2'b01:   booth_a = a_reg + m_reg;
      2'b10:   booth_a = a_reg - m_reg;
      default: booth_a = a_reg;
    endcase
    // arithmetic right shift of {A, Q, Q-1}
    sh_a = {booth_a[WIDTH+1], booth_a[WIDTH+1:1]};
    sh_q = {booth_a[0], q_reg[WIDTH:1]};
  end

  always_comb begin
    r_sh  = {dr, dq[WIDTH-1]};
    trial = {1'b0, r_sh} - {2'b00, dd};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_pend    <= 1'b0;
      a_reg       <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      q_1         <= 1'b0;
      dq          <= '0;
      dr          <= '0;
      dd          <= '0;
      result      <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            is_div      <= muordi;
            dbz_pend    <= 1'b0;
            if (!muordi) begin
              a_reg <= '0;
              m_reg <= {{2{ext1}}, opera1};
              q_reg <= {ext2, opera2};
              q_1   <= 1'b0;
              cnt   <= CW'(WIDTH + 1);
              state <= S_MUL;
            end else if (opera2 == '0) begin
              dq       <= '1;
              dr       <= opera1;
              dbz_pend <= 1'b1;
              state    <= S_DONE;
            end else begin
              // magnitudes; -(-2^(WIDTH-1)) wraps to the unsigned 2^(WIDTH-1)
              dq    <= neg1 ? -opera1 : opera1;
              dd    <= neg2 ? -opera2 : opera2;
              dr    <= '0;
              neg_q <= neg1 ^ neg2;
              neg_r <= neg1;
              cnt   <= CW'(WIDTH);
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          a_reg <= sh_a;
          q_reg <= sh_q;
          q_1   <= q_reg[0];
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_DONE;
        end
        S_DIV: begin
          if (trial[WIDTH+1]) begin
            dr <= r_sh[WIDTH-1:0];
            dq <= {dq[WIDTH-2:0], 1'b0};
          end else begin
            dr <= trial[WIDTH-1:0];
            dq <= {dq[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          // truncating division: quotient sign from the XOR, remainder
          // follows the dividend
          dq    <= neg_q ? -dq : dq;
          dr    <= neg_r ? -dr : dr;
          state <= S_DONE;
        end
        S_DONE: begin
          result      <= is_div ? {dr, dq} : {a_reg[WIDTH-2:0], q_reg};
          valid       <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= dbz_pend;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_muldiv_seq.sv
// Directed bench for booth_muldiv_seq: a vector table at WIDTH=32 plus
// hand-written sequences for divide-by-zero flag clearing, ignored start,
// mid-operation reset, and a WIDTH=8 instance.
module tb_booth_muldiv_seq;

  logic        clock = 1'b0;
  logic        reset, start, muordi, signed_op;
  logic [31:0] opera1, opera2;
  logic [63:0] result;
  logic        valid, busy, div_by_zero;

  logic        start8, md8, sg8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;
  logic        valid8, busy8, dbz8;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  booth_muldiv_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .muordi(muordi),
    .signed_op(signed_op), .opera1(opera1), .opera2(opera2),
    .result(result), .valid(valid), .busy(busy), .div_by_zero(div_by_zero));

  booth_muldiv_seq #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .start(start8), .muordi(md8),
    .signed_op(sg8), .opera1(a8), .opera2(b8),
    .result(result8), .valid(valid8), .busy(busy8), .div_by_zero(dbz8));

  typedef struct {
    string       nm;
    logic        md;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    logic        dbz;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive a request, take the accept edge E0, drop start at E0+1ns.
  task automatic launch(input logic md, input logic sg, input logic [31:0] a, input logic [31:0] b);
    muordi = md; signed_op = sg; opera1 = a; opera2 = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("valid_low_after_accept", {63'd0, valid}, 64'd0);
  endtask

  // Count edges after E0 until valid; optionally pulse start with other
  // operands so that it is sampled at edge 'inject'.
  task automatic wait_valid(input int inject, output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock); #1;
      if (valid) begin lat = n; break; end
      if (n == inject - 1) begin
        start = 1'b1; opera1 = 32'h55; opera2 = 32'h2;
      end else start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic op8(input logic md, input logic sg, input logic [7:0] a, input logic [7:0] b, output int lat);
    md8 = md; sg8 = sg; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock); #1;
      if (valid8) begin lat = n; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen;

    tv[0]  = '{"smul_m3x7",      1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 34, 1'b0};
    tv[1]  = '{"umul_max",       1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 34, 1'b0};
    tv[2]  = '{"smul_min_min",   1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 34, 1'b0};
    tv[3]  = '{"smul_maxpos",    1'b0, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 34, 1'b0};
    tv[4]  = '{"umul_x9",        1'b0, 1'b0, 32'h12345678, 32'h00000009, 64'h00000000_A3D70A38, 34, 1'b0};
    tv[5]  = '{"sdiv_m7_2",      1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b0};
    tv[6]  = '{"udiv_100_7",     1'b1, 1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 34, 1'b0};
    tv[7]  = '{"sdiv_ovf",       1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0};
    tv[8]  = '{"sdiv_7_m2",      1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0};
    tv[9]  = '{"udiv_max_1",     1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 34, 1'b0};
    tv[10] = '{"udiv_big_div",   1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34, 1'b0};
    tv[11] = '{"udiv_5_0",       1'b1, 1'b0, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1,  1'b1};
    tv[12] = '{"sdiv_m5_0",      1'b1, 1'b1, 32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 1,  1'b1};

    reset = 1'b1; start = 1'b0; muordi = 1'b0; signed_op = 1'b0;
    opera1 = '0; opera2 = '0;
    start8 = 1'b0; md8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_valid", {63'd0, valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Vector table; each launch lands in the previous op's valid cycle,
    // so back-to-back acceptance is exercised too.
    foreach (tv[i]) begin
      launch(tv[i].md, tv[i].sg, tv[i].a, tv[i].b);
      wait_valid(0, lat);
      chk({tv[i].nm, "_result"},  result, tv[i].exp);
      chk({tv[i].nm, "_latency"}, 64'(lat), 64'(tv[i].lat));
      chk({tv[i].nm, "_dbz"},     {63'd0, div_by_zero}, {63'd0, tv[i].dbz});
      chk({tv[i].nm, "_busy_at_valid"}, {63'd0, busy}, 64'd0);
    end

    // Divide-by-zero flag clears on the next accepted start
    launch(1'b1, 1'b0, 32'd5, 32'd0);
    wait_valid(0, lat);
    chk("dbz_set", {63'd0, div_by_zero}, 64'd1);
    launch(1'b0, 1'b0, 32'd6, 32'd7);
    chk("dbz_cleared_on_accept", {63'd0, div_by_zero}, 64'd0);
    wait_valid(0, lat);
    chk("mul_after_dbz", result, 64'd42);
    chk("mul_after_dbz_latency", 64'(lat), 64'd34);

    // Start during a running multiply is ignored
    launch(1'b0, 1'b0, 32'h11, 32'h3);
    wait_valid(5, lat);
    chk("ignored_start_result", result, 64'h33);
    chk("ignored_start_latency", 64'(lat), 64'd34);
    @(posedge clock); #1;
    chk("ignored_start_no_requeue", {63'd0, busy}, 64'd0);
    chk("valid_one_cycle", {63'd0, valid}, 64'd0);

    // Reset mid-operation abandons the op
    launch(1'b0, 1'b0, 32'h1234, 32'h10);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_result", result, 64'd0);
    chk("abort_valid", {63'd0, valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (valid) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    launch(1'b0, 1'b0, 32'd6, 32'd7);
    wait_valid(0, lat);
    chk("post_reset_mul", result, 64'h2A);
    chk("post_reset_latency", 64'(lat), 64'd34);

    // WIDTH=8 instance
    op8(1'b0, 1'b1, 8'h80, 8'hFF, lat);
    chk("w8_smul_min_m1", {48'd0, result8}, 64'h0080);
    chk("w8_smul_latency", 64'(lat), 64'd10);
    op8(1'b0, 1'b1, 8'hF9, 8'h05, lat);
    chk("w8_smul_m7x5", {48'd0, result8}, 64'hFFDD);
    op8(1'b1, 1'b1, 8'h80, 8'hFF, lat);
    chk("w8_sdiv_ovf", {48'd0, result8}, 64'h0080);
    chk("w8_sdiv_latency", 64'(lat), 64'd10);
    chk("w8_sdiv_dbz", {63'd0, dbz8}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
